// File: rtl/cfu_simd_mac_engine.sv
// SIMD multiply-accumulate engine on the CPU custom-instruction cmd/rsp interface.
// Activations are held in a reusable buffer, weights stream from a FIFO, and a RUN folds N words into one accumulator.
module cfu_simd_mac_engine #(
  parameter int LANE_W    = 8,
  parameter int ACT_DEPTH = 256,
  parameter int WGT_DEPTH = 256,
  parameter int NUM_ACC   = 4,
  parameter int ACC_W     = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [9:0]  cmd_payload_function_id,
  input  logic [31:0] cmd_payload_inputs_0,
  input  logic [31:0] cmd_payload_inputs_1,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_payload_outputs_0,
  output logic        busy
);
  localparam int LANES  = 32 / LANE_W;
  localparam int PROD_W = 2 * LANE_W + 2;
  localparam int ACT_AW = $clog2(ACT_DEPTH);
  localparam int WGT_AW = $clog2(WGT_DEPTH);
  localparam int ACC_IW = $clog2(NUM_ACC);

  localparam logic [ACT_AW:0]   ACT_ONE  = 1;
  localparam logic [WGT_AW:0]   WGT_ONE  = 1;
  localparam logic [WGT_AW-1:0] PTR_ONE  = 1;
  localparam logic [ACT_AW:0]   ACT_FULL = ACT_DEPTH[ACT_AW:0];
  localparam logic [WGT_AW:0]   WGT_FULL = WGT_DEPTH[WGT_AW:0];

  localparam logic [6:0] OP_SET_OFF   = 7'd0;
  localparam logic [6:0] OP_CLEAR_ACC = 7'd1;
  localparam logic [6:0] OP_PUSH_ACT  = 7'd2;
  localparam logic [6:0] OP_PUSH_WGT  = 7'd3;
  localparam logic [6:0] OP_RUN       = 7'd4;
  localparam logic [6:0] OP_CLEAR_BUF = 7'd5;
  localparam logic [6:0] OP_READ_ACC  = 7'd6;

  // S_RESP is the one-cycle slot that presents every response, so all ops share one response path.
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_RESP} state_t;

  state_t r_state, w_state_nxt;

  logic signed [LANE_W:0]   r_off;
  logic signed [ACC_W-1:0]  r_acc [NUM_ACC];
  logic [31:0]              r_act_mem [ACT_DEPTH];
  logic [31:0]              r_wgt_mem [WGT_DEPTH];
  logic [ACT_AW:0]          r_act_count;
  logic [WGT_AW:0]          r_wgt_count;
  logic [WGT_AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [ACT_AW:0]          r_idx, r_run_n;
  logic [ACC_IW-1:0]        r_run_k;
  logic [31:0]              r_act_q, r_wgt_q;
  logic                     r_rd_v;
  logic [31:0]              r_rsp_data, r_rsp_payload;
  logic                     r_rsp_valid;

  logic                     w_accept, w_is_mac, w_act_full, w_wgt_full, w_run_ok;
  logic                     w_run_go, w_act_we, w_wgt_we;
  logic [6:0]               w_op;
  logic [ACC_IW-1:0]        w_sel;
  logic signed [LANE_W+1:0] w_lane_a [LANES];
  logic signed [PROD_W-1:0] w_prod [LANES];
  logic signed [ACC_W-1:0]  w_word_sum, w_acc_new;

  assign cmd_ready             = (r_state == S_IDLE) && !r_rsp_valid;
  assign rsp_valid             = r_rsp_valid;
  assign rsp_payload_outputs_0 = r_rsp_payload;
  assign busy                  = (r_state == S_RUN) || (r_state == S_DRAIN);

  assign w_accept   = cmd_valid && cmd_ready;
  assign w_is_mac   = (cmd_payload_function_id[2:0] == 3'd1);
  assign w_op       = cmd_payload_function_id[9:3];
  assign w_sel      = cmd_payload_inputs_0[ACC_IW-1:0];
  assign w_act_full = (r_act_count == ACT_FULL);
  assign w_wgt_full = (r_wgt_count == WGT_FULL);
  assign w_run_ok   = (cmd_payload_inputs_0 != 32'd0)
                   && (cmd_payload_inputs_0 <= 32'(r_act_count))
                   && (cmd_payload_inputs_0 <= 32'(r_wgt_count));
  assign w_run_go   = w_accept && w_is_mac && (w_op == OP_RUN) && w_run_ok;
  assign w_act_we   = w_accept && w_is_mac && (w_op == OP_PUSH_ACT) && !w_act_full;
  assign w_wgt_we   = w_accept && w_is_mac && (w_op == OP_PUSH_WGT) && !w_wgt_full;

  // Offset is added in LANE_W+2 bits so that (a + offset) never overflows before the multiply.
  always_comb begin
    w_word_sum = '0;
    for (int j = 0; j < LANES; j++) begin
      w_lane_a[j] = (LANE_W+2)'($signed(r_act_q[j*LANE_W +: LANE_W])) + (LANE_W+2)'(r_off);
      w_prod[j]   = PROD_W'(w_lane_a[j]) * PROD_W'($signed(r_wgt_q[j*LANE_W +: LANE_W]));
      w_word_sum  = w_word_sum + ACC_W'(w_prod[j]);
    end
  end

  assign w_acc_new = r_acc[r_run_k] + w_word_sum;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // NOTE: every output of a combinational block is given a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_state_nxt = w_run_go ? S_RUN : S_RESP;
      S_RUN:   if (r_idx == r_run_n - ACT_ONE) w_state_nxt = S_DRAIN;
      S_DRAIN: w_state_nxt = S_RESP;
      S_RESP:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // NOTE: the buffers are plain RAM without reset; emptiness is tracked only by the reset pointers and counts.
  always_ff @(posedge clk) begin
    if (w_act_we) r_act_mem[r_act_count[ACT_AW-1:0]] <= cmd_payload_inputs_0;
    if (w_wgt_we) r_wgt_mem[r_wr_ptr] <= cmd_payload_inputs_0;
    if (r_state == S_RUN) begin
      r_act_q <= r_act_mem[r_idx[ACT_AW-1:0]];
      r_wgt_q <= r_wgt_mem[r_rd_ptr];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_off         <= '0;
      for (int i = 0; i < NUM_ACC; i++) r_acc[i] <= '0;
      r_act_count   <= '0;
      r_wgt_count   <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_idx         <= '0;
      r_run_n       <= '0;
      r_run_k       <= '0;
      r_rd_v        <= 1'b0;
      r_rsp_data    <= '0;
      r_rsp_payload <= '0;
      r_rsp_valid   <= 1'b0;
    end else begin
      r_rd_v <= 1'b0;
      if (r_rsp_valid && rsp_ready) r_rsp_valid <= 1'b0;
      if (r_rd_v) r_acc[r_run_k] <= w_acc_new;
      case (r_state)
        S_IDLE: if (w_accept) begin
          r_rsp_data <= '0;
          if (w_is_mac) begin
            case (w_op)
              OP_SET_OFF:   r_off <= $signed(cmd_payload_inputs_0[LANE_W:0]);
              OP_CLEAR_ACC: r_acc[w_sel] <= '0;
              OP_PUSH_ACT: begin
                if (w_act_full) r_rsp_data <= 32'hFFFF_FFFF;
                else begin
                  r_act_count <= r_act_count + ACT_ONE;
                  r_rsp_data  <= 32'(r_act_count + ACT_ONE);
                end
              end
              OP_PUSH_WGT: begin
                if (w_wgt_full) r_rsp_data <= 32'hFFFF_FFFF;
                else begin
                  r_wr_ptr    <= r_wr_ptr + PTR_ONE;
                  r_wgt_count <= r_wgt_count + WGT_ONE;
                  r_rsp_data  <= 32'(r_wgt_count + WGT_ONE);
                end
              end
              OP_RUN: begin
                if (!w_run_ok) r_rsp_data <= 32'h8000_0000;
                else begin
                  r_idx   <= '0;
                  r_run_n <= cmd_payload_inputs_0[ACT_AW:0];
                  r_run_k <= cmd_payload_inputs_1[ACC_IW-1:0];
                end
              end
              OP_CLEAR_BUF: begin
                r_act_count <= '0;
                r_wgt_count <= '0;
                r_wr_ptr    <= '0;
                r_rd_ptr    <= '0;
              end
              OP_READ_ACC:  r_rsp_data <= 32'(r_acc[w_sel]);
              default:      r_rsp_data <= '0;
            endcase
          end
        end
        S_RUN: begin
          r_idx       <= r_idx + ACT_ONE;
          r_rd_ptr    <= r_rd_ptr + PTR_ONE;
          r_wgt_count <= r_wgt_count - WGT_ONE;
          r_rd_v      <= 1'b1;
        end
        S_DRAIN: r_rsp_data <= 32'(w_acc_new);
        S_RESP: begin
          r_rsp_valid   <= 1'b1;
          r_rsp_payload <= r_rsp_data;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_cfu_simd_mac_engine.sv
// Self-checking bench for cfu_simd_mac_engine: directed cases plus randomized commands
// compared against a queue-based arithmetic model of the engine.
module tb_cfu_simd_mac_engine;
  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [9:0]  cmd_payload_function_id;
  logic [31:0] cmd_payload_inputs_0;
  logic [31:0] cmd_payload_inputs_1;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_payload_outputs_0;
  logic        busy;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: activations as an array, weights as a queue, accumulators as ints.
  logic [31:0] m_act [256];
  int          m_act_cnt;
  logic [31:0] m_wgt [$];
  int          m_acc [4];
  int          m_off;

  always #5 clk = ~clk;

  cfu_simd_mac_engine dut (
    .clk                     (clk),
    .reset                   (reset),
    .cmd_valid               (cmd_valid),
    .cmd_ready               (cmd_ready),
    .cmd_payload_function_id (cmd_payload_function_id),
    .cmd_payload_inputs_0    (cmd_payload_inputs_0),
    .cmd_payload_inputs_1    (cmd_payload_inputs_1),
    .rsp_valid               (rsp_valid),
    .rsp_ready               (rsp_ready),
    .rsp_payload_outputs_0   (rsp_payload_outputs_0),
    .busy                    (busy)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic int word_sum(input logic [31:0] a, input logic [31:0] w, input int off);
    int s;
    int aj;
    int wj;
    s = 0;
    for (int j = 0; j < 4; j++) begin
      aj = $signed(a[j*8 +: 8]);
      wj = $signed(w[j*8 +: 8]);
      s += (aj + off) * wj;
    end
    return s;
  endfunction

  function automatic void model_reset();
    m_act_cnt = 0;
    m_wgt.delete();
    m_off = 0;
    for (int i = 0; i < 4; i++) m_acc[i] = 0;
  endfunction

  function automatic void model(input logic [2:0] f3, input logic [6:0] f7,
                                input logic [31:0] a0, input logic [31:0] a1,
                                output logic [31:0] r, output int lat);
    int k;
    r   = 32'd0;
    lat = 1;
    if (f3 != 3'd1) return;
    case (f7)
      7'd0: m_off = $signed(a0[8:0]);
      7'd1: m_acc[a0[1:0]] = 0;
      7'd2: if (m_act_cnt == 256) r = 32'hFFFF_FFFF;
            else begin m_act[m_act_cnt] = a0; m_act_cnt++; r = m_act_cnt; end
      7'd3: if (m_wgt.size() == 256) r = 32'hFFFF_FFFF;
            else begin m_wgt.push_back(a0); r = m_wgt.size(); end
      7'd4: begin
        if (a0 == 0 || a0 > m_act_cnt || a0 > m_wgt.size()) r = 32'h8000_0000;
        else begin
          k = a1[1:0];
          for (int i = 0; i < int'(a0); i++) m_acc[k] += word_sum(m_act[i], m_wgt.pop_front(), m_off);
          r   = m_acc[k];
          lat = int'(a0) + 2;
        end
      end
      7'd5: begin m_act_cnt = 0; m_wgt.delete(); end
      7'd6: r = m_acc[a0[1:0]];
      default: r = 32'd0;
    endcase
  endfunction

  // Issues one command, counts edges until rsp_valid, optionally stalls rsp_ready for 'hold' cycles.
  task automatic send(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a0,
                      input logic [31:0] a1, input int hold, output logic [31:0] rsp, output int lat);
    int w;
    logic [31:0] first;
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    cmd_valid               = 1'b1;
    cmd_payload_function_id = {f7, f3};
    cmd_payload_inputs_0    = a0;
    cmd_payload_inputs_1    = a1;
    rsp_ready               = (hold == 0);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 2000) begin @(posedge clk); #1; lat++; end
    rsp = rsp_payload_outputs_0;
    if (hold > 0) begin
      first = rsp;
      for (int h = 0; h < hold; h++) begin
        @(posedge clk); #1;
        check("stall_valid", {31'd0, rsp_valid}, 32'd1);
        check("stall_payload", rsp_payload_outputs_0, first);
        check("stall_cmd_ready", {31'd0, cmd_ready}, 32'd0);
      end
      rsp_ready = 1'b1;
      @(posedge clk); #1;
      check("stall_release", {31'd0, rsp_valid}, 32'd0);
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] a0,
                       input logic [31:0] a1, input int hold, output logic [31:0] got);
    logic [31:0] exp_r;
    int          exp_l;
    int          lat;
    model(f3, f7, a0, a1, exp_r, exp_l);
    send(f3, f7, a0, a1, hold, got, lat);
    check($sformatf("f3=%0d f7=%0d in0=%0h rsp", f3, f7, a0), got, exp_r);
    check($sformatf("f3=%0d f7=%0d in0=%0h latency", f3, f7, a0), lat, exp_l);
  endtask

  logic [31:0] got;
  logic [31:0] a0, a1;
  logic [2:0]  f3;
  int          sel;
  int          w;

  initial begin
    reset = 1'b1; cmd_valid = 1'b0; rsp_ready = 1'b1;
    cmd_payload_function_id = '0; cmd_payload_inputs_0 = '0; cmd_payload_inputs_1 = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_payload", rsp_payload_outputs_0, 32'd0);
    check("reset_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    check("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);

    // Basic dot product, then offset applied to the retained activation.
    do_op(3'd1, 7'd0, 32'd0, 32'd0, 0, got);
    do_op(3'd1, 7'd2, 32'h0403_0201, 32'd0, 0, got);
    do_op(3'd1, 7'd3, 32'h0101_0101, 32'd0, 0, got);
    do_op(3'd1, 7'd4, 32'd1, 32'd0, 0, got);
    check("tp1_value", got, 32'd10);
    do_op(3'd1, 7'd0, 32'd1, 32'd0, 0, got);
    do_op(3'd1, 7'd1, 32'd0, 32'd0, 0, got);
    do_op(3'd1, 7'd3, 32'h0101_0101, 32'd0, 0, got);
    check("tp2_wgt_count_was_0", got, 32'd1);
    do_op(3'd1, 7'd4, 32'd1, 32'd0, 0, got);
    check("tp2_value", got, 32'd14);

    // Signed lane extremes.
    do_op(3'd1, 7'd5, 32'd0, 32'd0, 0, got);
    do_op(3'd1, 7'd0, 32'd0, 32'd0, 0, got);
    do_op(3'd1, 7'd1, 32'd0, 32'd0, 0, got);
    do_op(3'd1, 7'd2, 32'hFFFF_FF80, 32'd0, 0, got);
    do_op(3'd1, 7'd3, 32'h7F02_02FF, 32'd0, 0, got);
    do_op(3'd1, 7'd4, 32'd1, 32'd0, 0, got);
    check("tp3_value", got, 32'hFFFF_FFFD);
    do_op(3'd1, 7'd6, 32'd0, 32'd0, 0, got);
    check("tp3_read_acc", got, 32'hFFFF_FFFD);

    // Response back-pressure on a 3-word RUN into acc 2, acc 1 left alone.
    do_op(3'd1, 7'd5, 32'd0, 32'd0, 0, got);
    do_op(3'd1, 7'd0, 32'd3, 32'd0, 0, got);
    for (int i = 0; i < 3; i++) do_op(3'd1, 7'd2, $urandom, 32'd0, 0, got);
    for (int i = 0; i < 4; i++) do_op(3'd1, 7'd3, $urandom, 32'd0, 0, got);
    do_op(3'd1, 7'd4, 32'd1, 32'd1, 0, got);
    do_op(3'd1, 7'd4, 32'd3, 32'd2, 5, got);
    do_op(3'd1, 7'd6, 32'd1, 32'd0, 0, got);
    do_op(3'd1, 7'd6, 32'd2, 32'd0, 0, got);

    // Full buffers, rejected RUN lengths, weight pointer wrap.
    do_op(3'd1, 7'd5, 32'd0, 32'd0, 0, got);
    for (int i = 0; i < 256; i++) do_op(3'd1, 7'd2, $urandom, 32'd0, 0, got);
    do_op(3'd1, 7'd2, 32'h1234_5678, 32'd0, 0, got);
    check("act_full_rsp", got, 32'hFFFF_FFFF);
    do_op(3'd1, 7'd4, 32'd257, 32'd0, 0, got);
    check("run_too_long", got, 32'h8000_0000);
    do_op(3'd1, 7'd4, 32'd0, 32'd0, 0, got);
    check("run_zero", got, 32'h8000_0000);
    for (int i = 0; i < 256; i++) do_op(3'd1, 7'd3, $urandom, 32'd0, 0, got);
    do_op(3'd1, 7'd3, 32'h1234_5678, 32'd0, 0, got);
    check("wgt_full_rsp", got, 32'hFFFF_FFFF);
    do_op(3'd1, 7'd4, 32'd200, 32'd0, 0, got);
    for (int i = 0; i < 100; i++) do_op(3'd1, 7'd3, $urandom, 32'd0, 0, got);
    do_op(3'd1, 7'd4, 32'd150, 32'd1, 0, got);

    // Undecoded funct3 and funct7 leave state alone.
    do_op(3'd0, 7'd2, 32'hDEAD_BEEF, 32'd0, 0, got);
    do_op(3'd2, 7'd5, 32'd0, 32'd0, 0, got);
    do_op(3'd1, 7'd7, 32'd0, 32'd0, 0, got);
    do_op(3'd1, 7'd6, 32'd1, 32'd0, 0, got);

    for (int t = 0; t < 300; t++) begin
      sel = $urandom_range(0, 11);
      a0  = $urandom;
      a1  = $urandom;
      case (sel)
        0:       do_op(3'd1, 7'd0, a0, a1, 0, got);
        1:       do_op(3'd1, 7'd1, a0, a1, 0, got);
        2, 3, 4: do_op(3'd1, 7'd3, a0, a1, 0, got);
        5, 6:    do_op(3'd1, 7'd4, $urandom_range(0, 24), a1, 0, got);
        7:       do_op(3'd1, 7'd6, a0, a1, 0, got);
        8:       do_op(3'd1, 7'd2, a0, a1, 0, got);
        9: begin
          f3 = 3'($urandom_range(0, 6));
          if (f3 != 3'd0) f3 = f3 + 3'd1;
          do_op(f3, 7'($urandom_range(0, 127)), a0, a1, 0, got);
        end
        10:      do_op(3'd1, 7'($urandom_range(7, 127)), a0, a1, 0, got);
        default: if ($urandom_range(0, 9) == 0) do_op(3'd1, 7'd5, a0, a1, 0, got);
                 else do_op(3'd1, 7'd6, a0, a1, 0, got);
      endcase
    end

    // Reset in the middle of an 8-word RUN aborts it without a response.
    for (int i = 0; i < 8; i++) do_op(3'd1, 7'd2, $urandom, 32'd0, 0, got);
    for (int i = 0; i < 8; i++) do_op(3'd1, 7'd3, $urandom, 32'd0, 0, got);
    @(negedge clk);
    w = 0;
    while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
    if (w >= 200) check("cmd_ready_timeout", {31'd0, cmd_ready}, 32'd1);
    cmd_valid = 1'b1;
    cmd_payload_function_id = {7'd4, 3'd1};
    cmd_payload_inputs_0 = 32'd8;
    cmd_payload_inputs_1 = 32'd3;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("busy_mid_run", {31'd0, busy}, 32'd1);
    #1 reset = 1'b1;
    #1;
    check("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    do_op(3'd1, 7'd6, 32'd3, 32'd0, 0, got);
    check("abort_acc3", got, 32'd0);
    do_op(3'd1, 7'd3, 32'h0102_0304, 32'd0, 0, got);
    check("abort_wgt_count", got, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/cfu_simd_mac_engine.md
Name: cfu_simd_mac_engine

Overview:
- Parametrised successor to the single-word CFU MAC datapath.
- Holds an activation buffer and a weight FIFO, and keeps NUM_ACC independent accumulators.
- A single RUN command streams N packed SIMD words through the lane multipliers over multiple cycles, then returns one response.
- Sits on the CPU custom-instruction cmd/rsp interface.

Parameters:
- LANE_W, 8, signed lane width in bits; legal values 8 and 16. LANES = 32/LANE_W.
- ACT_DEPTH, 256, activation buffer depth in 32-bit words; power of two.
- WGT_DEPTH, 256, weight FIFO depth in 32-bit words; power of two.
- NUM_ACC, 4, number of accumulators; power of two.
- ACC_W, 32, accumulator width; two's-complement wrap on overflow.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command ready
- cmd_payload_function_id  in  10  [2:0] funct3, [9:3] funct7
- cmd_payload_inputs_0  in  32  operand 0
- cmd_payload_inputs_1  in  32  operand 1
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_payload_outputs_0  out  32  result
- busy  out  1  high while in RUN or DRAIN

Behaviour:
- Reset (async, active-high): applies to all of the following.
  - rsp_valid=0, rsp_payload_outputs_0=0, busy=0, state=IDLE.
  - All accumulators=0, offset=0.
  - Buffer pointers and counts=0.
  - Reset during RUN aborts the operation with no response.
- Handshake:
  - cmd_ready = (state==IDLE) && !rsp_valid.
  - A command is accepted on a clock edge with cmd_valid && cmd_ready.
  - rsp_valid stays high, with the payload stable, until an edge with rsp_ready=1.
  - rsp_valid falls on that edge.
- Opcode decode: only funct3=1 is decoded. Other funct3 values give rsp=0 with no state change. funct7 selects the operation:
  - 0 SET_OFF: offset <= in0[LANE_W:0] (signed, LANE_W+1 bits); rsp=0.
  - 1 CLEAR_ACC: acc[in0 mod NUM_ACC] <= 0; rsp=0.
  - 2 PUSH_ACT:
    - Not full: act[act_count] <= in0, act_count++, rsp = new act_count.
    - Full: write dropped, rsp=32'hFFFF_FFFF.
  - 3 PUSH_WGT:
    - Not full: enqueue in0 at the wrapping write pointer, wgt_count++, rsp = new wgt_count.
    - Full: write dropped, rsp=32'hFFFF_FFFF.
  - 4 RUN: N=in0, k = in1 mod NUM_ACC.
    - If N==0, N>act_count or N>wgt_count: rsp=32'h8000_0000, no state change, single-cycle response.
    - Otherwise: state IDLE->RUN.
  - 5 CLEAR_BUF: both buffers emptied (pointers and counts reset); rsp=0. Accumulators and offset are kept.
  - 6 READ_ACC: rsp = acc[in0 mod NUM_ACC], sign-extended or truncated to 32 bits.
  - Other funct7: rsp=0.
- Single-cycle ops: rsp_valid rises on the edge after acceptance.
- RUN state:
  - Each cycle i=0..N-1, read act[i] (synchronous read, 1-cycle latency) and pop one weight word.
  - Activations are not consumed, so repeated RUNs reuse the same activations against successive weight sets.
  - After issuing the last read: RUN->DRAIN.
  - DRAIN: the last product is accumulated, the response is set to acc[k], state->IDLE.
  - rsp_valid rises exactly N+2 edges after the acceptance edge.
- Lane arithmetic, per word: a_j and w_j are signed LANE_W-bit lanes, j=0..LANES-1, where lane 0 = bits [LANE_W-1:0].
  - Each lane product is (a_j + offset) * w_j, with a_j sign-extended to LANE_W+2 bits before the add.
  - The word sum is the sum of all lane products, sign-extended to ACC_W.
  - acc[k] += word sum each cycle; wrap mod 2^ACC_W.
- Weight FIFO pointers wrap at WGT_DEPTH. wgt_count decrements by N over the course of the RUN.

Test Plan:
- SET_OFF 0; PUSH_ACT 0x04030201; PUSH_WGT 0x01010101; RUN N=1,k=0 -> rsp=10, rsp_valid 3 edges after acceptance; wgt_count 0.
- SET_OFF 1; CLEAR_ACC 0; PUSH_WGT 0x01010101; RUN N=1,k=0 on the same activation -> rsp=14, which also confirms the activation was retained.
- Offset 0; act 0xFFFFFF80 (lanes -128,-1,-1,-1); wgt 0x7F0202FF -> (-128*-1)+(-1*2)+(-1*2)+(-1*127) = -3; rsp=0xFFFFFFFD. Then READ_ACC 0 -> 0xFFFFFFFD.
- Push ACT_DEPTH words, then one more PUSH_ACT -> rsp=0xFFFFFFFF and act_count unchanged. RUN N=act_count+1 -> rsp=0x80000000.
- Push 3 weights, RUN N=3 into k=2 with rsp_ready held low 5 cycles -> rsp_valid and payload held stable; cmd_ready low throughout; acc[1] unchanged.
- Assert reset mid-RUN (N=8, cycle 4) -> rsp_valid=0 immediately; READ_ACC on k after release -> 0; wgt_count 0.
